// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the boot-time instruction-memory loader.
package imem_pkg;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef enum logic [2:0] {
    CLEAR,
    HDR_HI,
    HDR_LO,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one combinational read port.
module imem_ram #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  import imem_pkg::*;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: clears the instruction store, takes a length-prefixed big-endian byte
// stream into it, then releases the CPU and serves its fetch port.
module imem_loader #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   address,
  output logic [31:0]   read_data,
  output logic          cpu_run,
  output logic          load_error,
  output logic [AW:0]   words_loaded
);
  import imem_pkg::*;

  loader_state_t state;
  logic [AW-1:0] clr_idx;
  logic [15:0]   hdr;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_word;

  logic          xfer;
  logic [15:0]   hdr_n;
  logic          hdr_bad;
  logic [15:0]   next_count;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          unused_addr_bits;

  assign xfer       = in_valid && in_ready;
  assign hdr_n      = {hdr[15:8], in_data};
  assign hdr_bad    = (hdr_n == 16'd0) || (hdr_n > 16'(DEPTH));
  assign next_count = 16'(words_loaded) + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      hdr          <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      cpu_run      <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(DEPTH - 1)) begin
            state    <= HDR_HI;
            in_ready <= 1'b1;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            hdr[15:8] <= in_data;
            state     <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            hdr[7:0] <= in_data;
            if (hdr_bad) begin
              state      <= ERROR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_word <= {asm_word[15:0], in_data};
            // The fourth byte completes a word; the RAM write happens on this same edge.
            if (byte_cnt == 2'd3) begin
              words_loaded <= words_loaded + (AW+1)'(1);
              if (next_count == hdr) begin
                state    <= DONE;
                in_ready <= 1'b0;
                cpu_run  <= 1'b1;
              end
            end
          end
        end
        DONE, ERROR: begin
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_idx;
    ram_wdata = NOP_WORD;
    if (!reset) begin
      if (state == CLEAR) begin
        ram_we = 1'b1;
      end else if (state == DATA && xfer && byte_cnt == 2'd3) begin
        ram_we    = 1'b1;
        ram_waddr = words_loaded[AW-1:0];
        ram_wdata = {asm_word, in_data};
      end
    end
  end

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (address[AW+1:2]),
    .rdata (ram_rdata)
  );

  // The core fetches nops until the whole program is in place.
  assign read_data = cpu_run ? ram_rdata : NOP_WORD;

  assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed tables plus randomized gapped loads
// compared against a simple array model of the loaded program.
module tb_imem_loader;
  import imem_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   address;
  logic [31:0]   read_data;
  logic          cpu_run;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int vec_count   = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_run;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] want;
  } read_vec_t;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .address      (address),
    .read_data    (read_data),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // A fetch returns the word loaded at (addr / 4) mod DEPTH once the program is running.
  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!model_run) return 32'h0;
    return model_mem[(a / 4) % DEPTH];
  endfunction

  task automatic syncClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit gapped);
    int t;
    if (gapped) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        syncClk();
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 64) begin
      syncClk();
      t++;
    end
    if (!in_ready) checkOutput("handshake timeout", 32'(in_ready), 32'd1);
    else syncClk();
    if (gapped) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic doReset();
    syncClk();
    reset    = 1'b1;
    in_valid = 1'b0;
    syncClk();
    reset     = 1'b0;
    model_run = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " cpu_run"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, " load_error"}, 32'(load_error), 32'd0);
    checkOutput({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic waitClear();
    int n = 0;
    bit bad = 1'b0;
    address = $urandom;
    while (!in_ready && n < DEPTH + 50) begin
      if (cpu_run || read_data !== 32'h0) bad = 1'b1;
      syncClk();
      n++;
    end
    checkOutput("clear cycles", 32'(n), 32'(DEPTH));
    checkOutput("nop while clearing", 32'(bad), 32'd0);
  endtask

  task automatic loadWords(input logic [31:0] words[$], input bit gapped);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(words.size());
    for (int i = 0; i < DEPTH; i++) model_mem[i] = (i < words.size()) ? words[i] : 32'h0;
    applyStimulus(n[15:8], gapped);
    applyStimulus(n[7:0], gapped);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int j = 3; j >= 0; j--) begin
        if (i == words.size() - 1 && j == 0) checkOutput("cpu_run before last byte", 32'(cpu_run), 32'd0);
        applyStimulus(w[8*j +: 8], gapped);
      end
    end
    in_valid = 1'b0;
    model_run = 1'b1;
    checkOutput("cpu_run after last byte", 32'(cpu_run), 32'd1);
    checkOutput("in_ready after load", 32'(in_ready), 32'd0);
    checkOutput("words_loaded", 32'(words_loaded), 32'(words.size()));
  endtask

  task automatic checkRead(input string name, input logic [31:0] a);
    address = a;
    #1;
    checkOutput(name, read_data, modelRead(a));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    read_vec_t   basic_tbl[5];
    logic [31:0] q[$];
    logic [15:0] bad_hdr[2];
    bit          stuck;

    basic_tbl[0] = '{"basic addr 0",        32'h0000_0000, 32'h2008_0002};
    basic_tbl[1] = '{"basic addr 4",        32'h0000_0004, 32'h200A_0002};
    basic_tbl[2] = '{"basic addr 8",        32'h0000_0008, 32'h0000_0000};
    basic_tbl[3] = '{"basic alias 0x404",   32'h0000_0404, 32'h200A_0002};
    basic_tbl[4] = '{"basic low bits 0x7",  32'hFFFF_F007, 32'h200A_0002};
    bad_hdr[0] = 16'h0000;
    bad_hdr[1] = 16'h0101;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    address   = 32'h0;
    model_run = 1'b0;

    $display("[TB] reset and clear pass");
    doReset();
    checkResetState("reset");
    waitClear();

    $display("[TB] basic load");
    q = '{32'h2008_0002, 32'h200A_0002};
    loadWords(q, 1'b0);
    for (int i = 0; i < 5; i++) begin
      address = basic_tbl[i].addr;
      #1;
      checkOutput(basic_tbl[i].name, read_data, basic_tbl[i].want);
    end
    syncClk();
    doReset();
    checkResetState("reset after done");
    address = 32'h0;
    #1;
    checkOutput("read gated after reset", read_data, 32'h0);
    waitClear();

    $display("[TB] gapped source");
    for (int trial = 0; trial < 3; trial++) begin
      if (trial == 0) q = '{32'h2008_0002, 32'h200A_0002};
      else begin
        q = {};
        repeat ($urandom_range(12, 1)) q.push_back($urandom);
      end
      loadWords(q, 1'b1);
      for (int i = 0; i < q.size() + 2; i++) checkRead("gapped word", 32'(i * 4));
      repeat (4) checkRead("gapped random addr", $urandom);
      syncClk();
      doReset();
      waitClear();
    end

    $display("[TB] illegal headers");
    for (int h = 0; h < 2; h++) begin
      applyStimulus(bad_hdr[h][15:8], 1'b0);
      checkOutput("no error after hi byte", 32'(load_error), 32'd0);
      applyStimulus(bad_hdr[h][7:0], 1'b0);
      in_valid = 1'b0;
      checkOutput("bad header load_error", 32'(load_error), 32'd1);
      checkOutput("bad header in_ready", 32'(in_ready), 32'd0);
      checkOutput("bad header cpu_run", 32'(cpu_run), 32'd0);
      doReset();
      checkResetState("reset after error");
      waitClear();
    end

    $display("[TB] reset mid-load");
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h03, 1'b0);
    repeat (6) applyStimulus(8'($urandom), 1'b0);
    in_data = 8'hA5;
    reset   = 1'b1;
    syncClk();
    reset    = 1'b0;
    in_valid = 1'b0;
    checkResetState("mid-load reset");
    waitClear();
    q = '{32'h0800_0017};
    loadWords(q, 1'b0);
    address = 32'h0;
    #1;
    checkOutput("reload addr 0", read_data, 32'h0800_0017);
    address = 32'h4;
    #1;
    checkOutput("reload addr 4", read_data, 32'h0);
    checkRead("reload addr 8", 32'h8);
    syncClk();
    doReset();
    waitClear();

    $display("[TB] full depth");
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(32'(i));
    loadWords(q, 1'b0);
    address = 32'h3FC;
    #1;
    checkOutput("full addr 0x3FC", read_data, 32'd255);
    address = 32'h400;
    #1;
    checkOutput("full alias 0x400", read_data, 32'd0);
    repeat (6) checkRead("full random addr", $urandom);
    syncClk();
    stuck = 1'b0;
    in_valid = 1'b1;
    repeat (8) begin
      in_data = 8'($urandom);
      if (in_ready) stuck = 1'b1;
      syncClk();
    end
    in_valid = 1'b0;
    checkOutput("no accept after done", 32'(stuck), 32'd0);
    checkOutput("words_loaded after extra", 32'(words_loaded), 32'(DEPTH));
    checkRead("full 0x3FC after extra", 32'h3FC);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle/pipelined MIPS core. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into an internal 256-word instruction store. It holds the CPU in reset until the program is fully loaded. Once the load completes, it serves the same combinational read port the core fetch stage already uses (`address`, `read_data`, word index `address[9:2]`).

## Interface

Parameters:
- `DEPTH` — default 256 — number of 32-bit instruction words.
- `AW` — default 8 — word-index width, equal to log2(DEPTH).

Ports:
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `reset` — in — 1 — synchronous, active-high reset.
- `in_data` — in — 8 — load-stream byte.
- `in_valid` — in — 1 — `in_data` is valid.
- `in_ready` — out — 1 — loader accepts a byte this cycle.
- `address` — in — 32 — CPU fetch byte address. Bits [1:0] and bits above AW+1 are ignored.
- `read_data` — out — 32 — instruction word. Combinational.
- `cpu_run` — out — 1 — program loaded; releases the core from reset.
- `load_error` — out — 1 — the header was illegal.
- `words_loaded` — out — AW+1 — count of words written so far.

## Operation

- A byte transfers on any rising edge where `in_valid && in_ready`. The source may insert idle cycles freely.
- Stream format:
  - 2-byte header N, most significant byte first. Legal range is 1..DEPTH.
  - Followed by N×4 data bytes, first byte → bits [31:24] of the word.
  - Word k is stored at index k.
- FSM states:
  - **CLEAR**: writes 0 to index `clr_idx`, incrementing each cycle from 0 to DEPTH-1, then goes to HDR_HI. `in_ready`=0.
  - **HDR_HI**: captures N[15:8] on transfer, then goes to HDR_LO.
  - **HDR_LO**: captures N[7:0] on transfer. If the full N is 0 or greater than DEPTH, go to ERROR; otherwise go to DATA.
  - **DATA**: a 2-bit byte counter shifts bytes into an assembly register. On the 4th byte, the word is written at index `words_loaded` and `words_loaded` increments. When `words_loaded` reaches N, go to DONE.
  - **DONE**: `cpu_run`=1 and `in_ready`=0. Terminal until reset; further bytes are never accepted.
  - **ERROR**: `load_error`=1, `cpu_run`=0, `in_ready`=0. Terminal until reset.
- `in_ready` = 1 only in HDR_HI, HDR_LO and DATA.
- Read port:
  - `read_data` = mem[`address[AW+1:2]`] when `cpu_run`=1, else 32'h0.
  - While loading, the core therefore fetches nops.
  - Addresses at or above DEPTH×4 alias modulo DEPTH.
- Unloaded locations read 0 (nop) because of the CLEAR pass.

## Timing

- Reset values:
  - `in_ready`=0, `cpu_run`=0, `load_error`=0, `words_loaded`=0.
  - State = CLEAR with `clr_idx`=0.
  - Byte counter and assembly register = 0.
- Reset asserted in any state, including mid-load, restarts CLEAR on the next edge. Partially loaded words are erased and `cpu_run` drops the cycle after reset is sampled.
- The CLEAR pass occupies exactly DEPTH cycles after reset deasserts. `in_ready` first rises on cycle DEPTH+1.
- The memory write occurs on the same edge that accepts the 4th byte. `words_loaded` updates on that edge.
- `cpu_run` rises on the edge following acceptance of the final data byte, i.e. together with entry into DONE.
- `load_error` rises on the edge that accepts the illegal header low byte.
- Simultaneous reset and transfer: reset wins and the byte is dropped.

## Structure

- Shared package `imem_pkg`:
  - `DEPTH`, `AW`.
  - State enum `loader_state_t` (CLEAR, HDR_HI, HDR_LO, DATA, DONE, ERROR).
  - `NOP_WORD` = 32'h0.
- Sub-module `imem_ram`:
  - DEPTH×32 array.
  - One synchronous write port (`we`, `waddr`, `wdata`) and one combinational read port.
  - No initial contents.
- `imem_loader` contains the FSM, header register, byte assembler and read gating. It instantiates `imem_ram`.

## Test plan

- **Reset clear:** reset 1 cycle, then idle → `in_ready`=0 for 256 cycles then 1. `cpu_run`=0 and `read_data`=0 throughout.
- **Basic load:** bytes 00 02 20 08 00 02 20 0A 00 02, back-to-back → `cpu_run`=1 one cycle after the last byte. Reads:
  - addr 0 → 32'h20080002
  - addr 4 → 32'h200A0002
  - addr 8 → 32'h0
  - `words_loaded` = 2
- **Gapped source:** same stream with `in_valid` toggling 1/0 randomly → identical memory contents. No byte is accepted while `in_valid`=0.
- **Illegal header:**
  - header 00 00 → `load_error`=1, `in_ready`=0, `cpu_run`=0.
  - header 01 01 (N=257) → same response.
- **Reset mid-load:** load N=3 but assert reset after 6 data bytes, then load N=1 word 32'h08000017 → addr 0 = 32'h08000017, addr 4 = 0.
- **Full depth and aliasing:** load N=256 words with value = index → addr 0x3FC = 255, addr 0x400 = 0 (aliases index 0). Extra bytes after DONE are not accepted.
